frame_config_writer: RTL and testbench

FRAME_CONFIG_WRITER -- requirements
Module: frame_config_writer

---
 rtl/frame_config_writer.sv | 194 +++++++++++++++++++
 tb/tb_frame_config_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_config_writer.sv
`default_nettype none
// ============================================================================
// Module   : frame_config_writer
// Purpose  : Accepts a stream of configuration words (header + data pairs) and
//            writes each data word into one row of an LHQD1 latch column. It
//            presents the data on FrameData, waits one setup cycle, pulses the
//            one-hot FrameStrobe for STROBE_CYCLES clocks, and then holds the
//            data for one more cycle before it accepts the next header.
//
// Ports    : CLK          - sole clock, rising edge
//            RESET        - asynchronous, active-high reset
//            WordIn       - configuration word (header or frame data)
//            WordValid    - WordIn valid
//            WordReady    - word accepted on the next rising edge if valid
//            FrameData    - data broadcast to latch D inputs
//            FrameStrobe  - one-hot latch enable per frame row
//            FrameCount   - frames written, saturating (optional)
//            ConfigDone   - sticky, end-of-configuration header seen
//            ConfigError  - sticky, malformed header seen
//
// Header   : sync = WordIn[31:24] (must be 8'hFA), index = WordIn[23:16].
//            An index below MAX_FRAMES starts a frame. Index 8'hFF marks the
//            end of configuration. Any other header is dropped and flagged.
//
// Options  : define FRAME_CONFIG_WRITER_COUNT_EN to add the FrameCount output.
//
// Revision : 1.0 - initial release
// ============================================================================
module frame_config_writer #(
    parameter int FRAME_BITS    = 32,
    parameter int MAX_FRAMES    = 20,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [FRAME_BITS-1:0] WordIn,
    input  logic                  WordValid,
    output logic                  WordReady,
    output logic [FRAME_BITS-1:0] FrameData,
    output logic [MAX_FRAMES-1:0] FrameStrobe,
`ifdef FRAME_CONFIG_WRITER_COUNT_EN
    output logic [15:0]           FrameCount,
`endif
    output logic                  ConfigDone,
    output logic                  ConfigError
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_data   = 3'd1;
    localparam logic [2:0] c_st_setup  = 3'd2;
    localparam logic [2:0] c_st_strobe = 3'd3;
    localparam logic [2:0] c_st_hold   = 3'd4;

    localparam logic [7:0]            c_sync        = 8'hFA;
    localparam logic [7:0]            c_index_done  = 8'hFF;
    localparam logic [7:0]            c_max_frames  = 8'(MAX_FRAMES);
    localparam logic [3:0]            c_strobe_last = 4'(STROBE_CYCLES - 1);
    localparam logic [MAX_FRAMES-1:0] c_strobe_one  = MAX_FRAMES'(1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [7:0]            r_index;
    logic [3:0]            r_strobe_cnt;
    logic [3:0]            w_strobe_cnt_next;
    logic [FRAME_BITS-1:0] r_frame_data;
    logic [MAX_FRAMES-1:0] r_frame_strobe;
    logic                  r_config_done;
    logic                  r_config_error;

    logic                  w_accept_state;
    logic                  w_load_index;
    logic                  w_load_data;
    logic                  w_set_done;
    logic                  w_set_error;
    logic [7:0]            w_hdr_sync;
    logic [7:0]            w_hdr_index;

    assign w_hdr_sync     = WordIn[31:24];
    assign w_hdr_index    = WordIn[23:16];
    assign w_accept_state = (r_state == c_st_idle) || (r_state == c_st_data);

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_strobe_cnt_next = r_strobe_cnt;
        w_load_index      = 1'b0;
        w_load_data       = 1'b0;
        w_set_done        = 1'b0;
        w_set_error       = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (WordValid) begin
                    if ((w_hdr_sync == c_sync) && (w_hdr_index < c_max_frames)) begin
                        w_load_index = 1'b1;
                        w_state_next = c_st_data;
                    end else if ((w_hdr_sync == c_sync) && (w_hdr_index == c_index_done)) begin
                        w_set_done = 1'b1;
                    end else begin
                        w_set_error = 1'b1;
                    end
                end
            end
            c_st_data: begin
                if (WordValid) begin
                    w_load_data  = 1'b1;
                    w_state_next = c_st_setup;
                end
            end
            c_st_setup: begin
                // Counter counts down the remaining strobe cycles after this one.
                w_strobe_cnt_next = c_strobe_last;
                w_state_next      = c_st_strobe;
            end
            c_st_strobe: begin
                if (r_strobe_cnt == 4'd0) begin
                    w_state_next = c_st_hold;
                end else begin
                    w_strobe_cnt_next = r_strobe_cnt - 4'd1;
                end
            end
            c_st_hold: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= c_st_idle;
            r_index        <= 8'd0;
            r_strobe_cnt   <= 4'd0;
            r_frame_data   <= '0;
            r_frame_strobe <= '0;
            r_config_done  <= 1'b0;
            r_config_error <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_strobe_cnt <= w_strobe_cnt_next;
            if (w_load_index) begin
                r_index <= w_hdr_index;
            end
            if (w_load_data) begin
                r_frame_data <= WordIn;
            end
            if (w_set_done) begin
                r_config_done <= 1'b1;
            end
            if (w_set_error) begin
                r_config_error <= 1'b1;
            end
            // The strobe is registered so the latch enables come straight
            // from flops and stay glitch-free. It is high only while STROBE is
            // the current state.
            if (w_state_next == c_st_strobe) begin
                r_frame_strobe <= c_strobe_one << r_index;
            end else begin
                r_frame_strobe <= '0;
            end
        end
    end

`ifdef FRAME_CONFIG_WRITER_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_frame_count <= 16'd0;
        end else if ((r_state == c_st_strobe) && (w_state_next == c_st_hold)
                     && (r_frame_count != 16'hFFFF)) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign FrameCount = r_frame_count;
`endif

    // WordReady is gated by RESET directly so it reads 0 for the whole reset.
    assign WordReady   = ~RESET & w_accept_state;
    assign FrameData   = r_frame_data;
    assign FrameStrobe = r_frame_strobe;
    assign ConfigDone  = r_config_done;
    assign ConfigError = r_config_error;

endmodule
`default_nettype wire

// File: tb/tb_frame_config_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_config_writer
// Purpose  : Directed self-checking bench for frame_config_writer with its
//            default parameters (32-bit words, 20 frames, 2-cycle strobe).
//            Inputs change and outputs are sampled on the falling clock edge.
//            Define FRAME_CONFIG_WRITER_COUNT_EN to cover FrameCount as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_config_writer;

    logic        clk;
    logic        rst;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] frame_data;
    logic [19:0] frame_strobe;
    logic        config_done;
    logic        config_error;
`ifdef FRAME_CONFIG_WRITER_COUNT_EN
    logic [15:0] frame_count;
`endif

    int total;
    int bad;

    frame_config_writer #(
        .FRAME_BITS    (32),
        .MAX_FRAMES    (20),
        .STROBE_CYCLES (2)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .WordIn      (word_in),
        .WordValid   (word_valid),
        .WordReady   (word_ready),
        .FrameData   (frame_data),
        .FrameStrobe (frame_strobe),
`ifdef FRAME_CONFIG_WRITER_COUNT_EN
        .FrameCount  (frame_count),
`endif
        .ConfigDone  (config_done),
        .ConfigError (config_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        word_valid = 1'b0;
        word_in    = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Full header + data frame from IDLE with WordValid dropped after data.
    task automatic run_frame(input logic [7:0] idx, input logic [31:0] data, input string tag);
        logic [19:0] exp_strobe;
        exp_strobe = 20'h1 << idx;
        @(negedge clk);
        total++; if (word_ready !== 1'b1) begin bad++; $display("FAIL %s idle_ready got=%b want=1", tag, word_ready); end
        word_in = {8'hFA, idx, 16'h0000}; word_valid = 1'b1;
        tick();
        total++; if (frame_strobe !== 20'h0 || word_ready !== 1'b1) begin bad++; $display("FAIL %s data_state got strobe=%h ready=%b want 0/1", tag, frame_strobe, word_ready); end
        word_in = data;
        tick();
        word_valid = 1'b0; word_in = 32'h0;
        total++; if (frame_data !== data) begin bad++; $display("FAIL %s setup_data got=%h want=%h", tag, frame_data, data); end
        total++; if (frame_strobe !== 20'h0 || word_ready !== 1'b0) begin bad++; $display("FAIL %s setup got strobe=%h ready=%b want 0/0", tag, frame_strobe, word_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (frame_strobe !== exp_strobe) begin bad++; $display("FAIL %s strobe%0d got=%h want=%h", tag, i, frame_strobe, exp_strobe); end
        end
        tick();
        total++; if (frame_strobe !== 20'h0 || frame_data !== data || word_ready !== 1'b0) begin
            bad++; $display("FAIL %s hold got strobe=%h data=%h ready=%b want 0/%h/0", tag, frame_strobe, frame_data, word_ready, data);
        end
        tick();
        total++; if (word_ready !== 1'b1 || frame_data !== data) begin bad++; $display("FAIL %s back_idle got ready=%b data=%h want 1/%h", tag, word_ready, frame_data, data); end
    endtask

    task automatic test_reset();
        rst = 1'b1; word_valid = 1'b0; word_in = 32'h0;
        tick();
        total++; if (word_ready !== 1'b0 || frame_data !== 32'h0 || frame_strobe !== 20'h0 || config_done !== 1'b0 || config_error !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got ready=%b data=%h strobe=%h done=%b err=%b want all 0", word_ready, frame_data, frame_strobe, config_done, config_error);
        end
`ifdef FRAME_CONFIG_WRITER_COUNT_EN
        total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h want=0", frame_count); end
`endif
        rst = 1'b0;
        #1;
        total++; if (word_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", word_ready); end
    endtask

    task automatic test_basic_frame();
        run_frame(8'd3, 32'hDEADBEEF, "basic");
        total++; if (config_error !== 1'b0 || config_done !== 1'b0) begin bad++; $display("FAIL basic_flags got err=%b done=%b want 0/0", config_error, config_done); end
    endtask

    task automatic test_bad_headers();
        apply_reset();
        @(negedge clk);
        word_in = 32'hFA14_0000; word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        total++; if (config_error !== 1'b1 || word_ready !== 1'b1 || frame_strobe !== 20'h0) begin
            bad++; $display("FAIL bad_index got err=%b ready=%b strobe=%h want 1/1/0", config_error, word_ready, frame_strobe);
        end
        apply_reset();
        @(negedge clk);
        word_in = 32'h5503_0000; word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        total++; if (config_error !== 1'b1 || word_ready !== 1'b1 || frame_strobe !== 20'h0) begin
            bad++; $display("FAIL bad_sync got err=%b ready=%b strobe=%h want 1/1/0", config_error, word_ready, frame_strobe);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (frame_strobe !== 20'h0) begin bad++; $display("FAIL bad_sync_nostrobe got=%h want=0", frame_strobe); end
        end
        run_frame(8'd1, 32'h1234_5678, "after_err");
        total++; if (config_error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", config_error); end
    endtask

    task automatic test_done();
        @(negedge clk);
        word_in = 32'hFAFF_0000; word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        total++; if (config_done !== 1'b1 || word_ready !== 1'b1 || frame_strobe !== 20'h0) begin
            bad++; $display("FAIL done_hdr got done=%b ready=%b strobe=%h want 1/1/0", config_done, word_ready, frame_strobe);
        end
        run_frame(8'd10, 32'hA5A5_0F0F, "after_done");
        total++; if (config_done !== 1'b1) begin bad++; $display("FAIL done_sticky got=%b want=1", config_done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        int wi, t0, t1, n0, n19, first0, first19;
        logic rdy;
        words[0] = 32'hFA00_0000; words[1] = 32'h0000_0001;
        words[2] = 32'hFA13_0000; words[3] = 32'h0013_0013;
        wi = 0; t0 = -1; t1 = -1; n0 = 0; n19 = 0; first0 = -1; first19 = -1;
        apply_reset();
        @(negedge clk);
        word_in = words[0]; word_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rdy = word_ready;
            tick();
            if (rdy && wi < 4) begin
                if (wi == 0) t0 = c;
                if (wi == 2) t1 = c;
                wi++;
                if (wi < 4) word_in = words[wi];
                else word_valid = 1'b0;
            end
            if (frame_strobe == 20'h00001) begin n0++; if (first0 < 0) first0 = c; end
            else if (frame_strobe == 20'h80000) begin n19++; if (first19 < 0) first19 = c; end
            else if (frame_strobe != 20'h0) begin
                total++; bad++; $display("FAIL b2b_strobe_shape cycle=%0d got=%h want one of 0/00001/80000", c, frame_strobe);
            end
        end
        word_valid = 1'b0;
        total++; if (wi !== 4) begin bad++; $display("FAIL b2b_words_accepted got=%0d want=4", wi); end
        total++; if (t1 - t0 !== 6) begin bad++; $display("FAIL b2b_period got=%0d want=6", t1 - t0); end
        total++; if (n0 !== 2 || n19 !== 2) begin bad++; $display("FAIL b2b_strobe_len got=%0d/%0d want=2/2", n0, n19); end
        total++; if (!(first0 >= 0 && first19 > first0)) begin bad++; $display("FAIL b2b_order got first0=%0d first19=%0d want first0<first19", first0, first19); end
    endtask

    task automatic test_reset_in_strobe();
        apply_reset();
        @(negedge clk);
        word_in = 32'hFA05_0000; word_valid = 1'b1;
        tick();
        word_in = 32'hCAFE_F00D;
        tick();
        word_valid = 1'b0;
        tick();
        total++; if (frame_strobe !== 20'h00020) begin bad++; $display("FAIL rst5_strobe_before got=%h want=00020", frame_strobe); end
        rst = 1'b1;
        #1;
        total++; if (frame_strobe !== 20'h0 || frame_data !== 32'h0 || word_ready !== 1'b0) begin
            bad++; $display("FAIL rst5_immediate got strobe=%h data=%h ready=%b want 0/0/0", frame_strobe, frame_data, word_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        total++; if (word_ready !== 1'b1) begin bad++; $display("FAIL rst5_release_ready got=%b want=1", word_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (frame_strobe !== 20'h0 || word_ready !== 1'b1) begin
                bad++; $display("FAIL rst5_no_resume got strobe=%h ready=%b want 0/1", frame_strobe, word_ready);
            end
        end
        run_frame(8'd7, 32'h0BAD_F00D, "after_rst");
    endtask

`ifdef FRAME_CONFIG_WRITER_COUNT_EN
    task automatic test_frame_count();
        apply_reset();
        run_frame(8'd0, 32'h1111_1111, "cnt0");
        run_frame(8'd2, 32'h2222_2222, "cnt1");
        @(negedge clk);
        word_in = 32'h5500_0000; word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        run_frame(8'd4, 32'h3333_3333, "cnt2");
        total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL frame_count got=%0d want=3", frame_count); end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; word_valid = 1'b0; word_in = 32'h0;
        test_reset();
        test_basic_frame();
        test_bad_headers();
        test_done();
        test_back_to_back();
        test_reset_in_strobe();
`ifdef FRAME_CONFIG_WRITER_COUNT_EN
        test_frame_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
